// File: rtl/jtframe_romrq_pkg.sv
// rtl/jtframe_romrq_pkg.sv - shared FSM encoding and geometry helper for the ROM request slot
package jtframe_romrq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Number of CPU words per SDRAM word, as a log2.
  function automatic int calc_ls(input int sw, input int dw);
    int r;
    int ratio;
    r = 0;
    ratio = sw / dw;
    for (int i = 0; i < 32; i++) begin
      if (ratio > 1) begin
        ratio = ratio >> 1;
        r++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jtframe_romrq_entry.sv
// rtl/jtframe_romrq_entry.sv - one cache line: valid/tag/data register with hit compare and slice mux
module jtframe_romrq_entry
  import jtframe_romrq_pkg::*;
#(
  parameter int TW  = 16,
  parameter int DW  = 8,
  parameter int SW  = 32,
  parameter int SLW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           wr,
  input  logic           wr_valid,
  input  logic [TW-1:0]  wr_tag,
  input  logic [SW-1:0]  wr_data,
  input  logic [TW-1:0]  tag,
  input  logic [SLW-1:0] sel,
  output logic           hit,
  output logic [DW-1:0]  dout
);

  logic          valid;
  logic [TW-1:0] tag_q;
  logic [SW-1:0] data_q;

  // A write carries its own valid so a stale fill can land without being usable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (wr) begin
      valid  <= wr_valid;
      tag_q  <= wr_tag;
      data_q <= wr_data;
    end else if (clr) begin
      valid  <= 1'b0;
    end
  end

  assign hit  = valid && (tag_q == tag);
  assign dout = hit ? data_q[sel*DW +: DW] : '0;

endmodule

// File: rtl/jtframe_romrq_slot.sv
// rtl/jtframe_romrq_slot.sv - two-entry word cache answering rom_ok, backed by an SDRAM req/ack/data_ok fetch
module jtframe_romrq_slot
  import jtframe_romrq_pkg::*;
#(
  parameter int AW   = 18,
  parameter int DW   = 8,
  parameter int SW   = 32,
  parameter int CNTW = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic [AW-1:0]                    addr,
  input  logic                             addr_ok,
  output logic [DW-1:0]                    dout,
  output logic                             data_ok,
  output logic [AW-calc_ls(SW, DW)-1:0]    sdram_addr,
  output logic                             req,
  input  logic                             ack,
  input  logic [SW-1:0]                    din,
  input  logic                             din_ok,
  output logic [CNTW-1:0]                  miss_cnt
);

  localparam int LS  = calc_ls(SW, DW);
  localparam int TW  = AW - LS;
  localparam int SLW = (LS > 0) ? LS : 1;

  state_t         state_q, state_d;
  logic           lru, victim, stale;
  logic           start, fill, fill_valid;
  logic           hit0, hit1, hit_any;
  logic [DW-1:0]  dout0, dout1;
  logic [TW-1:0]  tag;
  logic [SLW-1:0] sel;

  assign tag = addr[AW-1:LS];

  generate
    if (LS > 0) begin : g_sel
      assign sel = addr[LS-1:0];
    end else begin : g_nosel
      assign sel = '0;
    end
  endgenerate

  // A clr seen at any point of the fetch, including the data cycle, spoils the fill.
  assign fill_valid = !(stale || clr);

  jtframe_romrq_entry #(.TW(TW), .DW(DW), .SW(SW), .SLW(SLW)) u_e0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr       (fill && (victim == 1'b0)),
    .wr_valid (fill_valid),
    .wr_tag   (sdram_addr),
    .wr_data  (din),
    .tag      (tag),
    .sel      (sel),
    .hit      (hit0),
    .dout     (dout0)
  );

  jtframe_romrq_entry #(.TW(TW), .DW(DW), .SW(SW), .SLW(SLW)) u_e1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr       (fill && (victim == 1'b1)),
    .wr_valid (fill_valid),
    .wr_tag   (sdram_addr),
    .wr_data  (din),
    .tag      (tag),
    .sel      (sel),
    .hit      (hit1),
    .dout     (dout1)
  );

  assign hit_any = hit0 || hit1;
  assign data_ok = addr_ok && hit_any;
  assign dout    = hit0 ? dout0 : dout1;
  assign req     = (state_q == ST_REQ);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fill    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (addr_ok && !hit_any && !clr) begin
          start   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // ack and din_ok together collapse the WAIT state
        if (ack) begin
          if (din_ok) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (din_ok) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lru        <= 1'b0;
      victim     <= 1'b0;
      stale      <= 1'b0;
      sdram_addr <= '0;
      miss_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        sdram_addr <= tag;
        victim     <= lru;
        stale      <= 1'b0;
        if (miss_cnt != {CNTW{1'b1}}) miss_cnt <= miss_cnt + CNTW'(1);
      end
      if (clr) stale <= 1'b1;
      if (fill)                 lru <= ~victim;
      else if (addr_ok && hit0) lru <= 1'b1;
      else if (addr_ok && hit1) lru <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_romrq_slot.sv
// tb/tb_jtframe_romrq_slot.sv - directed table and sequence checks for jtframe_romrq_slot
module tb_jtframe_romrq_slot;

  localparam int AW   = 18;
  localparam int DW   = 8;
  localparam int SW   = 32;
  localparam int CNTW = 3;
  localparam int LS   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic            addr_ok = 1'b0;
  logic [DW-1:0]   dout;
  logic            data_ok;
  logic [AW-LS-1:0] sdram_addr;
  logic            req;
  logic            ack = 1'b0;
  logic [SW-1:0]   din = '0;
  logic            din_ok = 1'b0;
  logic [CNTW-1:0] miss_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic          ok;
    logic          exp_ok;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vt[6];

  jtframe_romrq_slot #(.AW(AW), .DW(DW), .SW(SW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .addr       (addr),
    .addr_ok    (addr_ok),
    .dout       (dout),
    .data_ok    (data_ok),
    .sdram_addr (sdram_addr),
    .req        (req),
    .ack        (ack),
    .din        (din),
    .din_ok     (din_ok),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!req && n < 8) begin
      tick();
      n++;
    end
    check(name, req, 1);
  endtask

  // data_dly 0 means din_ok together with ack
  task automatic finish_fetch(input logic [SW-1:0] d, input int ack_dly, input int data_dly);
    repeat (ack_dly) tick();
    ack = 1'b1;
    if (data_dly == 0) begin
      din = d;
      din_ok = 1'b1;
    end
    tick();
    ack = 1'b0;
    if (data_dly > 0) begin
      repeat (data_dly - 1) tick();
      din = d;
      din_ok = 1'b1;
      tick();
    end
    din_ok = 1'b0;
    din = '0;
    #1;
  endtask

  initial begin
    vt[0] = '{18'h11, 1'b1, 1'b1, 8'hBB};
    vt[1] = '{18'h12, 1'b1, 1'b1, 8'hCC};
    vt[2] = '{18'h13, 1'b1, 1'b1, 8'hDD};
    vt[3] = '{18'h10, 1'b1, 1'b1, 8'hAA};
    vt[4] = '{18'h11, 1'b0, 1'b0, 8'hBB};
    vt[5] = '{18'h14, 1'b0, 1'b0, 8'h00};

    // Test 1: reset state and first miss
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_ok", data_ok, 0);
    check("rst_dout", dout, 0);
    check("rst_req", req, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_sdram_addr", sdram_addr, 0);
    rst_n = 1'b1;
    tick();
    addr = 18'h10;
    addr_ok = 1'b1;
    #1;
    check("t1_miss_data_ok", data_ok, 0);
    tick();
    check("t1_req", req, 1);
    check("t1_sdram_addr", sdram_addr, 16'h4);
    check("t1_miss_cnt_early", miss_cnt, 1);
    repeat (2) tick();
    check("t1_req_held", req, 1);
    check("t1_data_ok_pending", data_ok, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_req_dropped", req, 0);
    tick();
    din = 32'hDDCCBBAA;
    din_ok = 1'b1;
    tick();
    din_ok = 1'b0;
    din = '0;
    #1;
    check("t1_data_ok", data_ok, 1);
    check("t1_dout", dout, 8'hAA);
    check("t1_miss_cnt", miss_cnt, 1);

    // Test 2: table sweep over the cached word
    for (int i = 0; i < 6; i++) begin
      addr = vt[i].a;
      addr_ok = vt[i].ok;
      #1;
      check($sformatf("t2_vec%0d_data_ok", i), data_ok, vt[i].exp_ok);
      check($sformatf("t2_vec%0d_dout", i), dout, vt[i].exp_dout);
      tick();
      check($sformatf("t2_vec%0d_req", i), req, 0);
    end
    check("t2_miss_cnt", miss_cnt, 1);
    din = 32'h11223344;
    din_ok = 1'b1;
    ack = 1'b1;
    tick();
    din_ok = 1'b0;
    ack = 1'b0;
    din = '0;
    addr = 18'h10;
    addr_ok = 1'b1;
    #1;
    check("t2_stray_dout", dout, 8'hAA);
    check("t2_stray_req", req, 0);

    // Test 3: LRU replacement
    addr = 18'h20;
    wait_req("t3_req_0x8");
    check("t3_sdram_addr_0x8", sdram_addr, 16'h8);
    finish_fetch(32'h44332211, 1, 1);
    check("t3_fill_0x8_ok", data_ok, 1);
    check("t3_fill_0x8_dout", dout, 8'h11);
    addr = 18'h10;
    #1;
    check("t3_touch_0x4", data_ok, 1);
    tick();
    addr = 18'h30;
    wait_req("t3_req_0xC");
    finish_fetch(32'h88776655, 0, 1);
    check("t3_fill_0xC_dout", dout, 8'h55);
    addr = 18'h10;
    #1;
    check("t3_0x4_kept_ok", data_ok, 1);
    check("t3_0x4_kept_dout", dout, 8'hAA);
    addr = 18'h20;
    #1;
    check("t3_0x8_evicted", data_ok, 0);
    addr_ok = 1'b0;
    check("t3_miss_cnt", miss_cnt, 3);
    tick();

    // Test 4: clr while WAIT, then clr with din_ok
    addr = 18'h40;
    addr_ok = 1'b1;
    wait_req("t4_req_a");
    ack = 1'b1;
    tick();
    ack = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    addr = 18'h10;
    #1;
    check("t4_clr_invalidates", data_ok, 0);
    addr = 18'h40;
    din = 32'h12345678;
    din_ok = 1'b1;
    tick();
    din_ok = 1'b0;
    #1;
    check("t4_stale_fill_a", data_ok, 0);
    check("t4_idle_a", req, 0);
    tick();
    check("t4_refetch_a", req, 1);
    check("t4_sdram_addr", sdram_addr, 16'h10);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    clr = 1'b1;
    din_ok = 1'b1;
    tick();
    clr = 1'b0;
    din_ok = 1'b0;
    #1;
    check("t4_stale_fill_b", data_ok, 0);
    tick();
    check("t4_refetch_b", req, 1);

    // Test 5: ack with din_ok, then address change mid-fetch
    finish_fetch(32'hCAFEF00D, 0, 0);
    check("t5_same_cycle_ok", data_ok, 1);
    check("t5_same_cycle_dout", dout, 8'h0D);
    addr = 18'h60;
    wait_req("t5_req_old");
    check("t5_sdram_addr_old", sdram_addr, 16'h18);
    addr = 18'h70;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    din = 32'h04030201;
    din_ok = 1'b1;
    tick();
    din_ok = 1'b0;
    #1;
    check("t5_new_addr_miss", data_ok, 0);
    tick();
    check("t5_second_req", req, 1);
    check("t5_sdram_addr_new", sdram_addr, 16'h1C);
    addr = 18'h61;
    #1;
    check("t5_old_filled_ok", data_ok, 1);
    check("t5_old_filled_dout", dout, 8'h02);

    // Test 6: async reset mid-REQ, then counter saturation
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", req, 0);
    check("t6_rst_data_ok", data_ok, 0);
    check("t6_rst_miss_cnt", miss_cnt, 0);
    check("t6_rst_dout", dout, 0);
    addr_ok = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < (1 << CNTW) + 3; i++) begin
      addr = AW'(i * 4);
      addr_ok = 1'b1;
      wait_req($sformatf("t6_req%0d", i));
      ack = 1'b1;
      din = SW'(i);
      din_ok = 1'b1;
      tick();
      ack = 1'b0;
      din_ok = 1'b0;
      addr_ok = 1'b0;
      #1;
      check($sformatf("t6_miss_cnt%0d", i), miss_cnt, (i + 1 < 7) ? i + 1 : 7);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
